tcdm_responder: RTL and testbench
=================================

# tcdm_responder

Synthesizable MP-channel TCDM responder: the target side of the hwpe TCDM protocol that the accelerator streamer drives as initiator. It maps each channel's byte address onto word-interleaved SRAM banks and arbitrates bank conflicts round-robin. It grants requests combinationally and returns read data with a fixed one-cycle latency. An optional LFSR-driven stall mode withholds grants pseudo-randomly to stress initiator back-pressure handling. It replaces the behavioural dummy memory in streamer and accelerator benches and serves as the local scratchpad in FPGA prototypes.

## Interface
- MP, 4, number of TCDM channels and of banks; power of two, 1..16.
- WORDS_PER_BANK, 1024, 32-bit words per bank; power of two.
- LFSR_SEED, 16'hACE1, stall LFSR reset value; must be nonzero.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- stall_en_i  in  1  enables pseudo-random grant withholding.
- req_i  in  MP  per-channel request.
- add_i  in  MP×32  per-channel byte address.
- wen_i  in  MP  1 = read, 0 = write.
- be_i  in  MP×4  per-channel byte enables; used on writes only.
- data_i  in  MP×32  per-channel write data.
- gnt_o  out  MP  per-channel grant; combinational from the current-cycle inputs.
- r_data_o  out  MP×32  per-channel read data, registered.
- r_valid_o  out  MP  per-channel response valid, registered.

## Operation
- Address decode: word = add_i[c] >> 2; bank = word mod MP; row = (word / MP) mod WORDS_PER_BANK.
  - Bits above the row range are ignored, so addresses wrap.
  - add_i[1:0] are ignored.
- Stall mask: stalled[c] = stall_en_i & lfsr[c].
  - lfsr is 16-bit Fibonacci with taps 16, 14, 13, 11.
  - It advances every cycle when not in reset, regardless of traffic.
- Eligible[c] = req_i[c] & ~stalled[c].
- Per-bank round-robin arbiter with pointer ptr[b]:
  - Among eligible channels targeting bank b, grant the first one found scanning upward from ptr[b]+1 (mod MP).
  - At most one grant per bank per cycle.
  - On a grant, ptr[b] becomes the granted channel; otherwise ptr[b] holds.
- Granted read: r_data_o[c] <= mem[bank][row] on the next edge.
- Granted write: for each byte i with be_i[c][i]=1, mem[bank][row] byte i <= data_i[c] byte i on the next edge. r_data_o[c] <= 0.
- r_valid_o[c] <= gnt_o[c] on every edge, for reads and writes alike.
- An ungranted request has no side effect. The initiator must hold it; the responder keeps no request state.
- Two writes to the same bank are never granted in the same cycle, so write-write races cannot occur.
- A read and a write granted to the same bank in the same cycle cannot occur either (one grant per bank).

## Timing
- Grant: same cycle as req_i (combinational path req/add → gnt).
- Response latency: exactly one cycle after grant. There is no back-pressure on responses.
- Read-after-write to the same address in consecutive cycles returns the newly written data.
- Reset values:
  - gnt_o: follows the inputs combinationally; forced to 0 while rst_i=1.
  - r_valid_o = 0, r_data_o = 0.
  - ptr[b] = MP-1, so channel 0 has first priority.
  - lfsr = LFSR_SEED.
- Memory contents are not cleared by reset. Writes are suppressed while rst_i=1.
- Reset in the cycle after a grant: the pending r_valid_o is dropped (0 after the edge).
- Deasserting stall_en_i takes effect in the same cycle.
- Each bank is a single-port array of 32-bit words (one access per cycle); it maps directly to SRAM macros.

## Test plan
- Aligned burst:
  - Stimulus: MP=4, all channels read addresses 0x100, 0x104, 0x108, 0x10C (preloaded 0xA0..0xA3).
  - Required: gnt_o=4'b1111 in the same cycle; next cycle r_valid_o=4'b1111 and r_data_o={0xA3,0xA2,0xA1,0xA0}.
- Byte-enable write:
  - Stimulus: write 0xDEADBEEF to 0x200 with be=4'b0101 over 0x11223344, then read 0x200.
  - Required: read returns 0x11AD33EF; the write response has r_valid=1 and r_data=0.
- Bank conflict:
  - Stimulus: channels 0 and 1 both read 0x0 and 0x10 (both bank 0), held for 3 cycles.
  - Required: grant order ch0, ch1, ch0; exactly one r_valid per cycle, one cycle after each grant.
- Stall:
  - Stimulus: stall_en_i=1, channel 0 holds a read for 64 cycles.
  - Required: gnt_o[0] equals ~lfsr[0] in every cycle, matching a reference LFSR from seed 0xACE1; every grant is followed by r_valid.
- Wrap-around:
  - Stimulus: write 0x55 to row WORDS_PER_BANK in bank 1, read row 0 in bank 1.
  - Required: read returns 0x55.
- Reset mid-operation:
  - Stimulus: assert rst_i in the cycle after a granted read.
  - Required: r_valid_o=0 and r_data_o=0 after the edge; memory contents preserved; ptr and lfsr reinitialised.

Source files
------------

// File: rtl/tcdm_responder.sv
// tcdm_responder: word-interleaved multi-bank TCDM target with per-bank round-robin arbitration and optional LFSR grant stalls
module tcdm_responder #(
    parameter int          MP             = 4,
    parameter int          WORDS_PER_BANK = 1024,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_en_i,
    input  logic [MP-1:0]    req_i,
    input  logic [MP*32-1:0] add_i,
    input  logic [MP-1:0]    wen_i,
    input  logic [MP*4-1:0]  be_i,
    input  logic [MP*32-1:0] data_i,
    output logic [MP-1:0]    gnt_o,
    output logic [MP*32-1:0] r_data_o,
    output logic [MP-1:0]    r_valid_o
);
    localparam int BW = MP > 1 ? $clog2(MP) : 1;
    localparam int RW = WORDS_PER_BANK > 1 ? $clog2(WORDS_PER_BANK) : 1;

    logic [15:0]   lfsr;
    logic [MP-1:0] elig;
    logic [MP-1:0] hit;
    logic [MP-1:0] rd_q;
    logic [BW-1:0] bank [MP];
    logic [BW-1:0] bank_q [MP];
    logic [BW-1:0] ptr [MP];
    logic [BW-1:0] win [MP];
    logic [RW-1:0] row [MP];
    logic [31:0]   dout [MP];
    logic          unused_addr;

    always_comb begin
        unused_addr = 1'b0;
        for (int c = 0; c < MP; c++) begin
            bank[c] = BW'(add_i[c*32+2 +: 30] % MP);
            row[c] = RW'((add_i[c*32+2 +: 30] / MP) % WORDS_PER_BANK);
            unused_addr ^= ^add_i[c*32 +: 2];
        end
    end

    assign elig = rst_i ? '0 : req_i & ~({MP{stall_en_i}} & lfsr[MP-1:0]);

    // Each bank scans channels upward from the one after its last winner.
    always_comb begin
        gnt_o = '0;
        hit = '0;
        for (int b = 0; b < MP; b++) begin
            win[b] = '0;
            for (int k = 1; k <= MP; k++) begin
                if (!hit[b] && elig[(int'(ptr[b]) + k) % MP] && bank[(int'(ptr[b]) + k) % MP] == BW'(b)) begin
                    hit[b] = 1'b1;
                    win[b] = BW'((int'(ptr[b]) + k) % MP);
                end
            end
            if (hit[b]) gnt_o[win[b]] = 1'b1;
        end
    end

    for (genvar b = 0; b < MP; b++) begin : g_bank
        logic [31:0] mem [WORDS_PER_BANK];
        logic [31:0] q;
        always_ff @(posedge clk_i) begin
            if (hit[b]) begin
                if (wen_i[win[b]]) begin
                    q <= mem[row[win[b]]];
                end else begin
                    for (int i = 0; i < 4; i++)
                        if (be_i[win[b]*4+i]) mem[row[win[b]]][i*8 +: 8] <= data_i[win[b]*32+i*8 +: 8];
                end
            end
        end
        assign dout[b] = q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr <= LFSR_SEED;
            r_valid_o <= '0;
            rd_q <= '0;
            for (int b = 0; b < MP; b++) ptr[b] <= BW'(MP - 1);
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            r_valid_o <= gnt_o;
            rd_q <= gnt_o & wen_i;
            for (int b = 0; b < MP; b++) if (hit[b]) ptr[b] <= win[b];
        end
        for (int c = 0; c < MP; c++) bank_q[c] <= bank[c];
    end

    // Bank output registers are steered back to the channel that was granted last cycle.
    always_comb begin
        r_data_o = '0;
        for (int c = 0; c < MP; c++) r_data_o[c*32 +: 32] = rd_q[c] ? dout[bank_q[c]] : 32'h0;
    end
endmodule

// File: tb/tb_tcdm_responder.sv
// tb_tcdm_responder: vector table plus hand sequences for conflicts, stalls and reset; responses checked via a scoreboard queue
module tb_tcdm_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall_en = 1'b0;
    logic [3:0]   req = '0;
    logic [3:0]   wen = '0;
    logic [127:0] add = '0;
    logic [127:0] data = '0;
    logic [15:0]  be = '0;
    logic [3:0]   gnt;
    logic [3:0]   r_valid;
    logic [127:0] r_data;
    int           n_cmp = 0;
    int           n_err = 0;

    typedef struct {
        logic [3:0]   rv;
        logic [127:0] rd;
    } resp_t;
    resp_t sb[$];

    typedef struct {
        logic [3:0]   req;
        logic [3:0]   wen;
        logic [127:0] add;
        logic [127:0] data;
        logic [15:0]  be;
        logic [3:0]   gnt;
        logic [3:0]   rv;
        logic [127:0] rd;
    } vec_t;
    vec_t vt[10];

    tcdm_responder dut (
        .clk_i(clk),
        .rst_i(rst),
        .stall_en_i(stall_en),
        .req_i(req),
        .add_i(add),
        .wen_i(wen),
        .be_i(be),
        .data_i(data),
        .gnt_o(gnt),
        .r_data_o(r_data),
        .r_valid_o(r_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are already driven; check grant mid-cycle, then compare the response after the edge.
    task automatic step(input string name, input logic [3:0] exp_gnt, input logic [3:0] exp_rv, input logic [127:0] exp_rd);
        resp_t r;
        #3;
        chk({name, " gnt"}, 128'(gnt), 128'(exp_gnt));
        sb.push_back('{rv: exp_rv, rd: exp_rd});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s scoreboard: got empty queue expected entry", name);
        end else begin
            r = sb.pop_front();
            chk({name, " r_valid"}, 128'(r_valid), 128'(r.rv));
            chk({name, " r_data"}, r_data, r.rd);
        end
    endtask

    initial begin
        logic [15:0] ref_lfsr;
        int guard;
        vt[0] = '{req: 4'hf, wen: 4'h0, add: {32'h10C, 32'h108, 32'h104, 32'h100}, data: {32'hA3, 32'hA2, 32'hA1, 32'hA0}, be: 16'hffff, gnt: 4'hf, rv: 4'hf, rd: '0};
        vt[1] = '{req: 4'hf, wen: 4'hf, add: {32'h10C, 32'h108, 32'h104, 32'h100}, data: '0, be: 16'h0, gnt: 4'hf, rv: 4'hf, rd: {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vt[2] = '{req: 4'h1, wen: 4'h0, add: {96'h0, 32'h200}, data: {96'h0, 32'h11223344}, be: 16'h000f, gnt: 4'h1, rv: 4'h1, rd: '0};
        vt[3] = '{req: 4'h1, wen: 4'h0, add: {96'h0, 32'h200}, data: {96'h0, 32'hDEADBEEF}, be: 16'h0005, gnt: 4'h1, rv: 4'h1, rd: '0};
        vt[4] = '{req: 4'h1, wen: 4'h1, add: {96'h0, 32'h200}, data: '0, be: 16'h0, gnt: 4'h1, rv: 4'h1, rd: {96'h0, 32'h11AD33EF}};
        vt[5] = '{req: 4'h4, wen: 4'h0, add: {32'h0, 32'h4004, 64'h0}, data: {32'h0, 32'h55, 64'h0}, be: 16'h0f00, gnt: 4'h4, rv: 4'h4, rd: '0};
        vt[6] = '{req: 4'h2, wen: 4'h2, add: {64'h0, 32'h4, 32'h0}, data: '0, be: 16'h0, gnt: 4'h2, rv: 4'h2, rd: {64'h0, 32'h55, 32'h0}};
        vt[7] = '{req: 4'h9, wen: 4'h8, add: {32'h104, 96'h0}, data: {96'h0, 32'h11110000}, be: 16'h000f, gnt: 4'h9, rv: 4'h9, rd: {32'hA1, 96'h0}};
        vt[8] = '{req: 4'h2, wen: 4'h0, add: {64'h0, 32'h10, 32'h0}, data: {64'h0, 32'h22220010, 32'h0}, be: 16'h00f0, gnt: 4'h2, rv: 4'h2, rd: '0};
        vt[9] = '{req: 4'h0, wen: 4'h0, add: '0, data: '0, be: 16'h0, gnt: 4'h0, rv: 4'h0, rd: '0};

        @(posedge clk);
        #1;
        req = 4'hf;
        wen = 4'hf;
        step("reset", 4'h0, 4'h0, '0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            req = vt[i].req;
            wen = vt[i].wen;
            add = vt[i].add;
            data = vt[i].data;
            be = vt[i].be;
            step($sformatf("vec%0d", i), vt[i].gnt, vt[i].rv, vt[i].rd);
        end

        be = '0;
        data = '0;
        req = 4'h1;
        wen = 4'h1;
        add = {96'h0, 32'h100};
        step("pre_rst_read", 4'h1, 4'h1, {96'h0, 32'hA0});
        rst = 1'b1;
        step("mid_rst", 4'h0, 4'h0, '0);
        rst = 1'b0;

        req = 4'h3;
        wen = 4'h3;
        add = {64'h0, 32'h10, 32'h0};
        step("conflict0", 4'h1, 4'h1, {96'h0, 32'h11110000});
        step("conflict1", 4'h2, 4'h2, {64'h0, 32'h22220010, 32'h0});
        step("conflict2", 4'h1, 4'h1, {96'h0, 32'h11110000});

        req = 4'h0;
        rst = 1'b1;
        step("rst2", 4'h0, 4'h0, '0);
        rst = 1'b0;
        stall_en = 1'b1;
        req = 4'h1;
        wen = 4'h1;
        add = {96'h0, 32'h100};
        ref_lfsr = 16'hACE1;
        for (int i = 0; i < 64; i++) begin
            step($sformatf("stall%0d", i), {3'b0, ~ref_lfsr[0]}, {3'b0, ~ref_lfsr[0]}, ref_lfsr[0] ? '0 : {96'h0, 32'hA0});
            ref_lfsr = lfsr_next(ref_lfsr);
        end
        guard = 0;
        while (!ref_lfsr[0] && guard < 40) begin
            step("stall_wait", 4'h1, 4'h1, {96'h0, 32'hA0});
            ref_lfsr = lfsr_next(ref_lfsr);
            guard++;
        end
        stall_en = 1'b0;
        step("stall_off", 4'h1, 4'h1, {96'h0, 32'hA0});
        req = 4'h0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
